requant_pipe: RTL and testbench
===============================

// Module: requant_pipe
// PURPOSE
//  Multi-lane requantizer for the attention head. Converts LANES signed D_W_ACC accumulators per beat into signed D_W outputs
//  as sat(round((acc + bias[ch]) * M[ch] >> E[ch])). Scale factors are per channel, held in an internal table written by a config port.
//  Sits between the matmul accumulator stream and the next int8 stage. Full valid/ready backpressure; no beat is dropped or duplicated.
// PARAMETERS
//  D_W       8   output element width (signed)
//  D_W_ACC   32  accumulator, bias and multiplier width (signed)
//  LANES     4   elements per beat; all lanes of a beat share one channel
//  N_CH      64  channel table depth; CH_W = $clog2(N_CH)
// PORTS
//  clk       in   1                clock
//  rst       in   1                reset, synchronous, active-high
//  cfg_we    in   1                write table entry cfg_addr
//  cfg_addr  in   CH_W             channel index to write
//  cfg_bias  in   D_W_ACC          bias for channel (signed)
//  cfg_m     in   D_W_ACC          multiplier for channel (signed)
//  cfg_e     in   SHAMT_SZ         right shift, 0..2*D_W_ACC-1; SHAMT_SZ = $clog2(2*D_W_ACC)
//  n_ch      in   CH_W+1           active channel count, 1..N_CH; static while streaming
//  in_data   in   LANES*D_W_ACC    lane l = bits [l*D_W_ACC +: D_W_ACC]
//  in_keep   in   LANES            per-lane keep, passed through
//  in_last   in   1                end of row; passed through
//  in_valid  in   1                input beat valid
//  in_ready  out  1                input beat accepted when in_valid && in_ready
//  out_data  out  LANES*D_W        lane l = bits [l*D_W +: D_W]
//  out_keep  out  LANES            delayed in_keep
//  out_last  out  1                delayed in_last
//  out_valid out  1                output beat valid
//  out_ready in   1                downstream ready
//  sat_flag  out  1                sticky: some kept lane saturated
//  sat_clr   in   1                clears sat_flag; a same-cycle set wins
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_keep=0, out_last=0, sat_flag=0, channel counter=0, all stage valids=0. Table contents are undefined.
//  Pipeline has 4 registered stages, so latency is 4 cycles from accept to out_valid when not stalled.
//   S0: table read at ch, computes acc+bias.
//   S1: multiply to a 2*D_W_ACC product.
//   S2: shift and round.
//   S3: saturate, then register the output.
//  Flow: adv = out_ready || !out_valid. All stages advance together on adv. in_ready = adv. Bubbles propagate as invalid stages.
//  out_valid stays high with out_data stable until out_ready is high. Throughput is 1 beat/cycle when out_ready is held high.
//  Channel counter ch increments on every accepted beat and wraps to 0 after n_ch-1. An accepted beat with in_last forces ch to 0 next cycle.
//  Bias add wraps at D_W_ACC bits; the product is the full 2*D_W_ACC-bit signed result.
//  Shift: q = p >>> E (arithmetic). frac = the low E bits of p.
//   E=0: no rounding.
//   frac > half: q+1.
//   frac == half: q+1 only if q is odd (round half to even).
//   Otherwise q.
//  Saturation clamps to [-2^(D_W-1), 2^(D_W-1)-1]. A clamp on a lane with keep=1 sets sat_flag. Lanes with keep=0 are still computed and output.
//  Config: cfg_we is accepted in any cycle. A write to the channel being read by S0 in the same cycle returns the old entry.
//   Writes while streaming are legal but unsynchronised with the data stream.
//  Mid-stream rst drops every in-flight beat. out_valid=0 on the next cycle, and no partial beat ever appears.
// CONFIGURATION
//  REQUANT_RELU_EN defined: after rounding, negative values become 0 before saturation. sat_flag is set only by positive overflow.
//  REQUANT_RELU_EN undefined: signed output as above. Latency is identical either way.
// STRUCTURE
//  requant_pkg: SHAMT_SZ, the cfg entry struct {bias, m, e}, and saturation bound constants derived from D_W.
//  The table is a single N_CH x (2*D_W_ACC+SHAMT_SZ) register array: 1 write port, 1 read port.
//  Sub-module requant_lane holds one lane's add/mul/shift/round/sat datapath with its stage enables. It is instantiated LANES times.
//  The top level owns the table, the channel counter, the valid/keep/last pipeline and sat_flag.
// TESTING
//  Exact: ch0 bias=28, M=3, E=2; lane0 acc=100 -> out 96; latency 4 cycles with out_ready=1.
//  Rounding, M=1, E=2, bias=0: acc 10 -> 2, 14 -> 4, -10 -> -2, 11 -> 3, -11 -> -3; E=0 with acc 5 -> 5.
//  Saturation: M=1, E=0, acc 1000 -> 127 with sat_flag=1; acc -1000 -> -128 (0 under REQUANT_RELU_EN); sat_clr -> 0.
//  Backpressure: 6 beats streamed, out_ready low on cycles 3-5 -> all 6 beats out in order, data held stable while stalled.
//  Channels: n_ch=3, 7 beats -> ch 0,1,2,0,1,2,0; in_last on beat 2 -> beat 3 uses ch 0; keep/last delayed intact.
//  Reset: rst asserted with 3 beats in flight -> out_valid=0 next cycle; next beat after reset uses ch 0.

Source files
------------

// File: rtl/requant_pkg.sv
// requant_pkg
//   Shared widths, derived constants and the channel-table entry type for
//   the requantizer (requant_pipe and requant_lane).
//   D_W       : output element width (signed)
//   D_W_ACC   : accumulator / bias / multiplier width (signed)
//   LANES     : elements per beat
//   N_CH      : channel table depth
//   P_W       : full signed product width (2*D_W_ACC)
//   SHAMT_SZ  : width of the per-channel right-shift amount
//   SAT_MAX / SAT_MIN : output clamp bounds, held at product width so the
//                       clamp compares need no further extension.
package requant_pkg;

    localparam int D_W      = 8;
    localparam int D_W_ACC  = 32;
    localparam int LANES    = 4;
    localparam int N_CH     = 64;
    localparam int CH_W     = $clog2(N_CH);
    localparam int P_W      = 2 * D_W_ACC;
    localparam int SHAMT_SZ = $clog2(P_W);

    localparam logic signed [P_W-1:0] SAT_MAX = P_W'((2 ** (D_W - 1)) - 1);
    localparam logic signed [P_W-1:0] SAT_MIN = P_W'(-(2 ** (D_W - 1)));

    // One channel's scale: (x + bias) * m >> e
    typedef struct packed {
        logic signed [D_W_ACC-1:0] bias;
        logic signed [D_W_ACC-1:0] m;
        logic [SHAMT_SZ-1:0]       e;
    } cfg_entry_t;

endpackage

// File: rtl/requant_lane.sv
// requant_lane
//   One lane of the requantizer datapath. Four registered stages, all
//   enabled together by adv:
//     S0  s0_sum  = acc + bias            (wraps at D_W_ACC bits)
//     S1  s1_prod = s0_sum * s0_m          (full P_W-bit signed product)
//     S2  s2_rnd  = round_half_even(s1_prod >>> s1_e)
//     S3  y       = sat(s2_rnd)            (optional ReLU before the clamp)
//   Ports:
//     clk, rst  : clock, synchronous active-high reset (clears y only)
//     adv       : pipeline advance enable
//     acc, bias : S0 operands (bias comes from the shared table read)
//     s0_m      : multiplier aligned with the S0 register
//     s1_e      : shift amount aligned with the S1 register
//     sat       : combinational, the value entering y is being clamped
//     y         : registered D_W-bit result
//   Build option REQUANT_RELU_EN: negative rounded values become 0 before
//   the clamp, so only positive overflow can assert sat.
module requant_lane
    import requant_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      adv,
    input  logic signed [D_W_ACC-1:0] acc,
    input  logic signed [D_W_ACC-1:0] bias,
    input  logic signed [D_W_ACC-1:0] s0_m,
    input  logic [SHAMT_SZ-1:0]       s1_e,
    output logic                      sat,
    output logic [D_W-1:0]            y
);

    logic signed [D_W_ACC-1:0] s0_sum;
    logic signed [P_W-1:0]     s1_prod;
    logic signed [P_W-1:0]     s2_rnd;

    logic signed [P_W-1:0]     prod_n;
    logic signed [P_W-1:0]     rnd_n;
    logic [D_W-1:0]            y_n;

    logic signed [P_W-1:0]     q;
    logic [P_W-1:0]            mask;
    logic [P_W-1:0]            frac;
    logic [P_W-1:0]            half;
    logic                      round_up;
    logic signed [P_W-1:0]     v;

    // Both operands sign-extended to P_W so the truncated product is exact.
    assign prod_n = $signed({{D_W_ACC{s0_sum[D_W_ACC-1]}}, s0_sum})
                  * $signed({{D_W_ACC{s0_m[D_W_ACC-1]}}, s0_m});

    // Round half to even on the bits shifted out.
    always_comb begin
        q        = s1_prod >>> s1_e;
        mask     = (P_W'(1) << s1_e) - P_W'(1);
        frac     = s1_prod & mask;
        // Only meaningful for e > 0; the e == 0 case is excluded below.
        half     = P_W'(1) << (s1_e - SHAMT_SZ'(1));
        round_up = 1'b0;
        if (s1_e != '0) begin
            if (frac > half) begin
                round_up = 1'b1;
            end else if (frac == half) begin
                round_up = q[0];
            end
        end
        // q + 1 cannot overflow: for e > 0, |q| < 2^(P_W-1-e).
        rnd_n = q + P_W'(round_up);
    end

    always_comb begin
        v = s2_rnd;
`ifdef REQUANT_RELU_EN
        if (s2_rnd[P_W-1]) begin
            v = '0;
        end
`endif
        sat = 1'b0;
        y_n = v[D_W-1:0];
        if (v > SAT_MAX) begin
            sat = 1'b1;
            y_n = SAT_MAX[D_W-1:0];
        end else if (v < SAT_MIN) begin
            sat = 1'b1;
            y_n = SAT_MIN[D_W-1:0];
        end
    end

    // Inner stages carry no reset: their contents only matter while the
    // matching valid bit in the top level is set.
    always_ff @(posedge clk) begin
        if (adv) begin
            s0_sum  <= acc + bias;
            s1_prod <= prod_n;
            s2_rnd  <= rnd_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y <= '0;
        end else if (adv) begin
            y <= y_n;
        end
    end

endmodule

// File: rtl/requant_pipe.sv
// requant_pipe
//   Multi-lane requantizer: out = sat(round((acc + bias[ch]) * M[ch] >> E[ch]))
//   for LANES signed D_W_ACC accumulators per beat, all lanes of a beat
//   sharing one channel. Latency is 4 cycles from accept to out_valid.
//   Ports:
//     clk, rst           : clock, synchronous active-high reset
//     cfg_we, cfg_addr,
//     cfg_bias, cfg_m,
//     cfg_e              : channel table write port (any cycle)
//     n_ch               : active channel count, 1..N_CH
//     in_data/keep/last,
//     in_valid, in_ready : input beat stream
//     out_data/keep/last,
//     out_valid,out_ready: output beat stream
//     sat_flag, sat_clr  : sticky saturation flag and its clear
//   Build option REQUANT_RELU_EN: ReLU before saturation (see requant_lane).
//
//   Handshake: a beat moves on a side when valid && ready are both high at
//   a rising clk edge. out_valid, once high, holds with out_data/keep/last
//   stable until out_ready is sampled high. in_ready does not depend on
//   in_valid. The whole pipeline moves as one: adv = out_ready || !out_valid,
//   in_ready = adv, and empty slots travel as invalid stages.
module requant_pipe
    import requant_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [CH_W-1:0]          cfg_addr,
    input  logic [D_W_ACC-1:0]       cfg_bias,
    input  logic [D_W_ACC-1:0]       cfg_m,
    input  logic [SHAMT_SZ-1:0]      cfg_e,
    input  logic [CH_W:0]            n_ch,
    input  logic [LANES*D_W_ACC-1:0] in_data,
    input  logic [LANES-1:0]         in_keep,
    input  logic                     in_last,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [LANES*D_W-1:0]     out_data,
    output logic [LANES-1:0]         out_keep,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sat_flag,
    input  logic                     sat_clr
);

    cfg_entry_t                tbl [N_CH];
    cfg_entry_t                rd;
    logic [CH_W-1:0]           ch;

    logic                      adv;
    logic                      accept;
    logic                      sat_set;
    logic [LANES-1:0]          lane_sat;

    logic                      s0_v, s1_v, s2_v;
    logic [LANES-1:0]          s0_keep, s1_keep, s2_keep;
    logic                      s0_last, s1_last, s2_last;
    logic signed [D_W_ACC-1:0] s0_m;
    logic [SHAMT_SZ-1:0]       s0_e, s1_e;

    assign adv      = out_ready || !out_valid;
    assign in_ready = adv;
    assign accept   = in_valid && adv;

    // Asynchronous read, write at the edge: a same-cycle write to the entry
    // S0 is reading returns the old entry.
    assign rd = tbl[ch];

    always_ff @(posedge clk) begin
        if (cfg_we) begin
            tbl[cfg_addr] <= '{bias: cfg_bias, m: cfg_m, e: cfg_e};
        end
    end

    // Channel counter; >= rather than == so a shrunk n_ch still wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch <= '0;
        end else if (accept) begin
            if (in_last || ({1'b0, ch} >= n_ch - (CH_W + 1)'(1))) begin
                ch <= '0;
            end else begin
                ch <= ch + CH_W'(1);
            end
        end
    end

    // Per-channel scale follows the beat: m is used in S1, e in S2.
    always_ff @(posedge clk) begin
        if (adv) begin
            s0_m <= rd.m;
            s0_e <= rd.e;
            s1_e <= s0_e;
        end
    end

    // Valid/keep/last side pipeline, aligned with the lane stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_v      <= 1'b0;
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            out_valid <= 1'b0;
            s0_keep   <= '0;
            s1_keep   <= '0;
            s2_keep   <= '0;
            out_keep  <= '0;
            s0_last   <= 1'b0;
            s1_last   <= 1'b0;
            s2_last   <= 1'b0;
            out_last  <= 1'b0;
        end else if (adv) begin
            s0_v      <= in_valid;
            s1_v      <= s0_v;
            s2_v      <= s1_v;
            out_valid <= s2_v;
            s0_keep   <= in_keep;
            s1_keep   <= s0_keep;
            s2_keep   <= s1_keep;
            out_keep  <= s2_keep;
            s0_last   <= in_last;
            s1_last   <= s0_last;
            s2_last   <= s1_last;
            out_last  <= s2_last;
        end
    end

    // The flag rises in the same cycle the saturating beat appears on the
    // output; a set in the same cycle as sat_clr wins.
    assign sat_set = adv && s2_v && |(s2_keep & lane_sat);

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= 1'b0;
        end else if (sat_set) begin
            sat_flag <= 1'b1;
        end else if (sat_clr) begin
            sat_flag <= 1'b0;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        requant_lane u_lane (
            .clk  (clk),
            .rst  (rst),
            .adv  (adv),
            .acc  (in_data[l*D_W_ACC +: D_W_ACC]),
            .bias (rd.bias),
            .s0_m (s0_m),
            .s1_e (s1_e),
            .sat  (lane_sat[l]),
            .y    (out_data[l*D_W +: D_W])
        );
    end

endmodule

// File: tb/tb_requant_pipe.sv
`timescale 1ns/1ps
module tb_requant_pipe;
    import requant_pkg::*;

    // Expected beat layout: {last, keep, data, sat}
    localparam int EXP_W = 1 + LANES + LANES * D_W + 1;
`ifdef REQUANT_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif
    localparam int SMAX = (2 ** (D_W - 1)) - 1;
    localparam int SMIN = -(2 ** (D_W - 1));

    logic                     clk;
    logic                     rst;
    logic                     cfg_we;
    logic [CH_W-1:0]          cfg_addr;
    logic [D_W_ACC-1:0]       cfg_bias;
    logic [D_W_ACC-1:0]       cfg_m;
    logic [SHAMT_SZ-1:0]      cfg_e;
    logic [CH_W:0]            n_ch;
    logic [LANES*D_W_ACC-1:0] in_data;
    logic [LANES-1:0]         in_keep;
    logic                     in_last;
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*D_W-1:0]     out_data;
    logic [LANES-1:0]         out_keep;
    logic                     out_last;
    logic                     out_valid;
    logic                     out_ready;
    logic                     sat_flag;
    logic                     sat_clr;

    requant_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_bias  (cfg_bias),
        .cfg_m     (cfg_m),
        .cfg_e     (cfg_e),
        .n_ch      (n_ch),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_flag  (sat_flag),
        .sat_clr   (sat_clr)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- model state / scoreboard ----------------
    int                 m_bias [N_CH];
    int                 m_m    [N_CH];
    int                 m_e    [N_CH];
    int                 m_ch;
    logic [EXP_W-1:0]   exp_q[$];
    int                 out_l0[$];
    int                 n_out;
    int                 checks;
    int                 failures;
    bit                 done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Floor division by 2^e, then round half to even using the remainder.
    function automatic longint round_he(input longint p, input int e);
        logic signed [127:0] pw, pe, q, rem;
        if (e == 0) return p;
        pw  = p;
        pe  = 128'sd1 <<< e;
        q   = pw / pe;
        rem = pw - q * pe;
        if (rem < 0) begin
            q   = q - 1;
            rem = rem + pe;
        end
        if ((2 * rem > pe) || ((2 * rem == pe) && q[0])) q = q + 1;
        return longint'(q);
    endfunction

    function automatic logic [EXP_W-1:0] beat_model(input logic [LANES*D_W_ACC-1:0] d,
                                                    input logic [LANES-1:0] k,
                                                    input logic lst, input int c);
        logic [LANES*D_W-1:0] od;
        logic                 s;
        int                   a, sum;
        longint               p, r;
        s  = 1'b0;
        od = '0;
        for (int l = 0; l < LANES; l++) begin
            a   = d[l*D_W_ACC +: D_W_ACC];
            sum = a + m_bias[c];
            p   = longint'(sum) * longint'(m_m[c]);
            r   = round_he(p, m_e[c]);
            if (RELU && r < 0) r = 0;
            if (r > SMAX) begin
                r = SMAX;
                if (k[l]) s = 1'b1;
            end else if (r < SMIN) begin
                r = SMIN;
                if (k[l]) s = 1'b1;
            end
            od[l*D_W +: D_W] = r[D_W-1:0];
        end
        return {lst, k, od, s};
    endfunction

    function automatic logic [LANES*D_W_ACC-1:0] mk(input int a0, input int a1, input int a2, input int a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [LANES*D_W-1:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {a3[D_W-1:0], a2[D_W-1:0], a1[D_W-1:0], a0[D_W-1:0]};
    endfunction

    // Compare process: every negedge, against the model queue.
    task automatic monitor();
        logic [EXP_W-1:0] e;
        while (!done) begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                m_ch = 0;
            end else begin
                check("in_ready_rule", in_ready, out_ready || !out_valid);
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL spurious_out actual=%h required=no_beat", out_data);
                    end else begin
                        e = exp_q[0];
                        check("out_data", out_data, e[LANES*D_W:1]);
                        check("out_keep", out_keep, e[EXP_W-2 -: LANES]);
                        check("out_last", out_last, e[EXP_W-1]);
                        if (e[0]) check("sat_flag_set", sat_flag, 1);
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            out_l0.push_back(int'($signed(out_data[D_W-1:0])));
                            n_out++;
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(beat_model(in_data, in_keep, in_last, m_ch));
                    if (in_last || m_ch >= int'(n_ch) - 1) m_ch = 0;
                    else m_ch++;
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cfg_write(input int c, input int b, input int m, input int e);
        cfg_we   = 1'b1;
        cfg_addr = c[CH_W-1:0];
        cfg_bias = b;
        cfg_m    = m;
        cfg_e    = e[SHAMT_SZ-1:0];
        @(posedge clk);
        #1;
        cfg_we   = 1'b0;
        m_bias[c] = b;
        m_m[c]    = m;
        m_e[c]    = e;
    endtask

    task automatic send(input logic [LANES*D_W_ACC-1:0] d, input logic [LANES-1:0] k, input logic lst);
        bit acc_ok;
        int guard;
        in_data  = d;
        in_keep  = k;
        in_last  = lst;
        in_valid = 1'b1;
        guard    = 0;
        do begin
            @(negedge clk);
            acc_ok = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc_ok && guard < 100);
        check("send_accept", acc_ok, 1);
        in_valid = 1'b0;
    endtask

    // Waits for the next output beat; lat counts cycles since the last edge.
    task automatic expect_out(input string name, input logic [LANES*D_W-1:0] req,
                              input logic sat_req, output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_valid"}, out_valid, 1);
        check(name, out_data, req);
        check({name, "_sat"}, sat_flag, sat_req);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int g;
        g = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || out_valid) && g < 60) begin
            @(negedge clk);
            g++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int n0;
        int exp_ch[11];
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_bias = '0; cfg_m = '0; cfg_e = '0;
        n_ch = 1; in_data = '0; in_keep = '0; in_last = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1; sat_clr = 1'b0;
        m_ch = 0; n_out = 0; checks = 0; failures = 0; done = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_keep", out_keep, 0);
        check("rst_out_last", out_last, 0);
        check("rst_sat_flag", sat_flag, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Exact value and latency
        cfg_write(0, 28, 3, 2);
        send(mk(100, 0, -28, 4), 4'hF, 1'b0);
        expect_out("exact", pk(96, 21, 0, 24), 1'b0, lat);
        check("latency", lat, 4);

        // Round half to even, E=2
        cfg_write(0, 0, 1, 2);
        send(mk(10, 14, -10, 11), 4'hF, 1'b0);
        expect_out("round_a", pk(2, 4, RELU ? 0 : -2, 3), 1'b0, lat);
        send(mk(-11, 0, 0, 0), 4'hF, 1'b0);
        expect_out("round_b", pk(RELU ? 0 : -3, 0, 0, 0), 1'b0, lat);
        cfg_write(0, 0, 1, 0);
        send(mk(5, 0, 0, 0), 4'hF, 1'b0);
        expect_out("round_e0", pk(5, 0, 0, 0), 1'b0, lat);

        // Saturation; sat_clr held through the beat so the set must win
        sat_clr = 1'b1;
        send(mk(1000, -1000, 5, -5), 4'hF, 1'b0);
        expect_out("sat", pk(SMAX, RELU ? 0 : SMIN, 5, RELU ? 0 : -5), 1'b1, lat);
        sat_clr = 1'b0;
        @(negedge clk);
        check("sat_clr", sat_flag, 0);
        @(posedge clk);
        #1;
        // Clamp on an unkept lane is output but does not raise the flag
        send(mk(1000, 0, 0, 0), 4'b1110, 1'b0);
        expect_out("sat_nokeep", pk(SMAX, 0, 0, 0), 1'b0, lat);

        // Backpressure: out_ready low for three cycles mid-stream
        out_l0.delete();
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++) send(mk(i * 7 - 20, i, -i, 50 * i), 4'hF, i == 5);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", n_out - n0, 6);
        for (int i = 0; i < 6; i++) begin
            if (i < out_l0.size()) begin
                check("bp_order", out_l0[i], (RELU && (i * 7 - 20) < 0) ? 0 : i * 7 - 20);
            end
        end

        // Channel sequencing and in_last reset of the counter
        cfg_write(0, 0, 1, 0);
        cfg_write(1, 0, 2, 0);
        cfg_write(2, 0, 3, 0);
        cfg_write(3, 0, 4, 0);
        n_ch = 3;
        out_l0.delete();
        for (int i = 0; i < 7; i++) send(mk(10, i, 0, 0), i[3:0], i == 6);
        drain();
        n_ch = 4;
        for (int i = 0; i < 4; i++) send(mk(10, i, 0, 0), 4'hF, i == 2);
        drain();
        exp_ch = '{10, 20, 30, 10, 20, 30, 10, 10, 20, 30, 10};
        check("ch_count", out_l0.size(), 11);
        for (int i = 0; i < 11; i++) begin
            if (i < out_l0.size()) check("ch_seq", out_l0[i], exp_ch[i]);
        end

        // Mid-stream reset with three beats in flight
        for (int i = 0; i < 3; i++) send(mk(10, 0, 0, 0), 4'hF, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_flush_valid", out_valid, 0);
        repeat (8) @(posedge clk);
        #1;
        send(mk(10, 0, 0, 0), 4'hF, 1'b0);
        expect_out("rst_ch0", pk(10, 0, 0, 0), 1'b0, lat);

        drain();
        done = 1'b1;
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
